// File: rtl/capping_sequencer.sv
// Bottle capping sequencer: positions the bottle, drives the capping press, and requests cork refills, with a timeout on refill.
// All outputs are registered (1-cycle latency from inputs); garrafa is ignored while capping; optional counter enabled by CONTADOR_GARRAFAS_EN.
module capping_sequencer #(
    parameter int unsigned POS_CICLOS     = 4,
    parameter int unsigned PRENSA_CICLOS  = 8,
    parameter int unsigned TIMEOUT_CICLOS = 255
) (
    input  logic       CLKplaca,
    input  logic       ini_n,
    input  logic       garrafa,
    input  logic       TemR,
    output logic       Tampar,
    output logic       adicionar,
    output logic       esteira,
    output logic       alarme,
    output logic       erro,
    output logic [7:0] garrafas_cnt
);

    localparam logic [7:0] POS_LOAD     = 8'(POS_CICLOS - 1);
    localparam logic [7:0] PRENSA_LOAD  = 8'(PRENSA_CICLOS - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        ESPERA,
        POSICIONA,
        TAMPA,
        LIBERA,
        SEM_ROLHA,
        ERRO
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;

    always_ff @(posedge CLKplaca) begin
        if (!ini_n) begin
            state     <= ESPERA;
            timer     <= 8'd0;
            Tampar    <= 1'b0;
            adicionar <= 1'b0;
            esteira   <= 1'b1;
            alarme    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            // Outputs decoded from the next state so they line up with the state register.
            Tampar    <= (state_nxt == TAMPA);
            adicionar <= (state_nxt == SEM_ROLHA) && (state != SEM_ROLHA);
            esteira   <= (state_nxt == ESPERA) || (state_nxt == LIBERA);
            alarme    <= (state_nxt == SEM_ROLHA) || (state_nxt == ERRO);
            erro      <= (state_nxt == ERRO);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ESPERA: begin
                if (garrafa) begin
                    state_nxt = POSICIONA;
                    timer_nxt = POS_LOAD;
                end
            end
            POSICIONA: begin
                // A bottle that leaves before settling is never capped.
                if (!garrafa) begin
                    state_nxt = ESPERA;
                end else if (timer == 8'd0) begin
                    if (TemR) begin
                        state_nxt = TAMPA;
                        timer_nxt = PRENSA_LOAD;
                    end else begin
                        state_nxt = SEM_ROLHA;
                        timer_nxt = TIMEOUT_LOAD;
                    end
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            TAMPA: begin
                if (timer == 8'd0) begin
                    state_nxt = LIBERA;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            LIBERA: begin
                if (!garrafa) begin
                    state_nxt = ESPERA;
                end
            end
            SEM_ROLHA: begin
                if (TemR) begin
                    state_nxt = TAMPA;
                    timer_nxt = PRENSA_LOAD;
                end else if (timer == 8'd0) begin
                    state_nxt = ERRO;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            ERRO: begin
                state_nxt = ERRO;
            end
            default: begin
                state_nxt = ESPERA;
                timer_nxt = 8'd0;
            end
        endcase
    end

`ifdef CONTADOR_GARRAFAS_EN
    always_ff @(posedge CLKplaca) begin
        if (!ini_n) begin
            garrafas_cnt <= 8'd0;
        end else if ((state == TAMPA) && (state_nxt == LIBERA)) begin
            garrafas_cnt <= garrafas_cnt + 8'd1;
        end
    end
`else
    assign garrafas_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_capping_sequencer.sv
// Directed bench for capping_sequencer: per-cycle vector table plus hand-written wrap and mid-capping reset sequences.
module tb_capping_sequencer;

`ifdef CONTADOR_GARRAFAS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam logic [7:0] K1 = CNT_ON ? 8'd1 : 8'd0;
    localparam logic [7:0] K2 = CNT_ON ? 8'd2 : 8'd0;

    logic       clk = 1'b0;
    logic       ini_n;
    logic       garrafa;
    logic       temr;

    logic       tampar_a, adic_a, est_a, alarme_a, erro_a;
    logic [7:0] cnt_a;
    logic       tampar_b, adic_b, est_b, alarme_b, erro_b;
    logic [7:0] cnt_b;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    always #5 clk = ~clk;

    capping_sequencer dut (
        .CLKplaca(clk), .ini_n(ini_n), .garrafa(garrafa), .TemR(temr),
        .Tampar(tampar_a), .adicionar(adic_a), .esteira(est_a),
        .alarme(alarme_a), .erro(erro_a), .garrafas_cnt(cnt_a)
    );

    capping_sequencer #(.TIMEOUT_CICLOS(10)) dut_to (
        .CLKplaca(clk), .ini_n(ini_n), .garrafa(garrafa), .TemR(temr),
        .Tampar(tampar_b), .adicionar(adic_b), .esteira(est_b),
        .alarme(alarme_b), .erro(erro_b), .garrafas_cnt(cnt_b)
    );

    typedef struct {
        bit         sel;
        bit         rst_n;
        bit         g;
        bit         t;
        int         n;
        logic [4:0] flags;   // {Tampar, adicionar, esteira, alarme, erro}
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit sel, bit rst_n, bit g, bit t, int n,
                                bit tp, bit ad, bit es, bit al, bit er, logic [7:0] cnt);
        vec_t r;
        r.sel = sel; r.rst_n = rst_n; r.g = g; r.t = t; r.n = n;
        r.flags = {tp, ad, es, al, er};
        r.cnt = cnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if ((tampar_a && adic_a) || (tampar_b && adic_b)) excl_viol++;
    endtask

    task automatic run_rec(input vec_t r, input int idx);
        logic [4:0] f;
        logic [7:0] c;
        ini_n   = r.rst_n;
        garrafa = r.g;
        temr    = r.t;
        for (int k = 0; k < r.n; k++) begin
            tick();
            f = r.sel ? {tampar_b, adic_b, est_b, alarme_b, erro_b}
                      : {tampar_a, adic_a, est_a, alarme_a, erro_a};
            c = r.sel ? cnt_b : cnt_a;
            checks++;
            if (f !== r.flags || c !== r.cnt) begin
                errors++;
                $display("FAIL vec%0d cyc%0d: tampar/adic/est/alarme/erro=%b cnt=%0d, expected %b cnt=%0d",
                         idx, k, f, c, r.flags, r.cnt);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int tampar_cycles;
        ini_n = 1'b0; garrafa = 1'b0; temr = 1'b1;

        // Nominal capping with corks present; garrafa dropping mid-press is ignored.
        tbl.push_back(mk(0, 0,0,1, 2,  0,0,1,0,0, 8'd0));
        tbl.push_back(mk(0, 1,0,1, 3,  0,0,1,0,0, 8'd0));
        tbl.push_back(mk(0, 1,1,1, 4,  0,0,0,0,0, 8'd0));
        tbl.push_back(mk(0, 1,1,1, 3,  1,0,0,0,0, 8'd0));
        tbl.push_back(mk(0, 1,0,1, 2,  1,0,0,0,0, 8'd0));
        tbl.push_back(mk(0, 1,1,1, 3,  1,0,0,0,0, 8'd0));
        tbl.push_back(mk(0, 1,1,1, 2,  0,0,1,0,0, K1));
        tbl.push_back(mk(0, 1,0,1, 3,  0,0,1,0,0, K1));
        // Short 2-cycle bottle pulse: no capping.
        tbl.push_back(mk(0, 1,1,1, 2,  0,0,0,0,0, K1));
        tbl.push_back(mk(0, 1,0,1, 8,  0,0,1,0,0, K1));
        // Out of corks: one refill pulse, 20 cycles of alarm, then capping.
        tbl.push_back(mk(0, 1,1,0, 4,  0,0,0,0,0, K1));
        tbl.push_back(mk(0, 1,1,0, 1,  0,1,0,1,0, K1));
        tbl.push_back(mk(0, 1,1,0, 19, 0,0,0,1,0, K1));
        tbl.push_back(mk(0, 1,1,1, 8,  1,0,0,0,0, K1));
        tbl.push_back(mk(0, 1,1,1, 1,  0,0,1,0,0, K2));
        tbl.push_back(mk(0, 1,0,1, 2,  0,0,1,0,0, K2));
        // Timeout instance: ERRO 10 cycles after refill request, cleared only by reset.
        tbl.push_back(mk(1, 0,0,0, 2,  0,0,1,0,0, 8'd0));
        tbl.push_back(mk(1, 1,1,0, 4,  0,0,0,0,0, 8'd0));
        tbl.push_back(mk(1, 1,1,0, 1,  0,1,0,1,0, 8'd0));
        tbl.push_back(mk(1, 1,1,0, 9,  0,0,0,1,0, 8'd0));
        tbl.push_back(mk(1, 1,1,0, 3,  0,0,0,1,1, 8'd0));
        tbl.push_back(mk(1, 1,0,1, 5,  0,0,0,1,1, 8'd0));
        tbl.push_back(mk(1, 0,0,1, 1,  0,0,1,0,0, 8'd0));
        tbl.push_back(mk(1, 1,0,1, 2,  0,0,1,0,0, 8'd0));

        for (int i = 0; i < tbl.size(); i++) run_rec(tbl[i], i);

        // 256 bottles from a cleared counter: wraps back to 0.
        tampar_cycles = 0;
        temr = 1'b1;
        for (int b = 1; b <= 256; b++) begin
            garrafa = 1'b1;
            for (int k = 0; k < 13; k++) begin
                tick();
                if (tampar_a) tampar_cycles++;
            end
            garrafa = 1'b0;
            tick();
            tick();
            if (b == 255) check("cnt_after_255", cnt_a, CNT_ON ? 255 : 0);
            if (b == 256) check("cnt_wrap_256", cnt_a, 0);
        end
        check("tampar_cycles_256", tampar_cycles, 256 * 8);

        // Reset during the third press cycle.
        garrafa = 1'b1;
        repeat (4) tick();
        check("pos_esteira_low", est_a, 0);
        repeat (3) tick();
        check("tampa_cycle3_tampar", tampar_a, 1);
        ini_n = 1'b0;
        tick();
        check("reset_mid_tampa_tampar", tampar_a, 0);
        check("reset_mid_tampa_cnt", cnt_a, 0);
        garrafa = 1'b0;
        ini_n = 1'b1;
        repeat (12) tick();
        check("after_reset_tampar", tampar_a, 0);
        check("after_reset_esteira", est_a, 1);
        check("after_reset_cnt", cnt_a, 0);

        check("tampar_adicionar_exclusive", excl_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
